// File: rtl/seq_accum_adder.sv
// Multi-beat sequential accumulator: sums NUM_BEATS operand pairs, then holds the result until acknowledged.
// Optional build macro SEQ_ACCUM_ADDER_SAT_EN selects saturating (clamp to all-ones) instead of wrapping results.
module seq_accum_adder #(
    parameter int WIDTH     = 8,
    parameter int NUM_BEATS = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    output logic [WIDTH-1:0] sum_out,
    output logic             overflow,
    output logic             done,
    input  logic             out_ack,
    output logic             busy
);
    localparam int CNT_W = $clog2(NUM_BEATS + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACC,
        ST_DONE
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] sum_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             ovf_reg;
    logic             ovf_next;
    logic             ovf_out_reg;
    logic             done_reg;
    logic             in_ready_reg;
    logic             busy_reg;
    logic [WIDTH+1:0] sum_wide;
    logic             beat_accept;

    // Two guard bits hold the carry of acc + a + b; any of them set means the true sum left range.
    always_comb begin
        sum_wide = {2'b00, acc_reg} + {2'b00, input1} + {2'b00, input2};
        ovf_next = ovf_reg | (|sum_wide[WIDTH+1:WIDTH]);
`ifdef SEQ_ACCUM_ADDER_SAT_EN
        acc_next = ovf_next ? {WIDTH{1'b1}} : sum_wide[WIDTH-1:0];
`else
        acc_next = sum_wide[WIDTH-1:0];
`endif
    end

    assign beat_accept = in_valid && in_ready_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= ST_IDLE;
            acc_reg      <= '0;
            cnt_reg      <= '0;
            ovf_reg      <= 1'b0;
            sum_reg      <= '0;
            ovf_out_reg  <= 1'b0;
            done_reg     <= 1'b0;
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        state_reg    <= ST_ACC;
                        acc_reg      <= '0;
                        cnt_reg      <= '0;
                        ovf_reg      <= 1'b0;
                        in_ready_reg <= 1'b1;
                        busy_reg     <= 1'b1;
                    end
                end
                ST_ACC: begin
                    if (beat_accept) begin
                        acc_reg <= acc_next;
                        ovf_reg <= ovf_next;
                        cnt_reg <= cnt_reg + CNT_ONE;
                        // Result registers load from the post-add value on the final beat edge.
                        if (cnt_reg == LAST_BEAT) begin
                            state_reg    <= ST_DONE;
                            sum_reg      <= acc_next;
                            ovf_out_reg  <= ovf_next;
                            in_ready_reg <= 1'b0;
                            done_reg     <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    // start in the same cycle as out_ack is deliberately dropped.
                    if (out_ack) begin
                        state_reg <= ST_IDLE;
                        done_reg  <= 1'b0;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg    <= ST_IDLE;
                    done_reg     <= 1'b0;
                    in_ready_reg <= 1'b0;
                    busy_reg     <= 1'b0;
                end
            endcase
        end
    end

    assign sum_out  = sum_reg;
    assign overflow = ovf_out_reg;
    assign done     = done_reg;
    assign in_ready = in_ready_reg;
    assign busy     = busy_reg;

endmodule
